// File: rtl/timer_share_ctrl.sv
// Two-requester round-robin owner of a shared mod-41 interval counter.
// The winner holds the counter for exactly len cycles, then one DONE cycle.

module timer_share_lenchk (
    input  logic [5:0] i_len,
    output logic       o_legal
);
    assign o_legal = (i_len != 6'd0) && (i_len <= 6'd41);
endmodule

module timer_share_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [5:0] len0,
    input  logic [5:0] len1,
    output logic [1:0] gnt,
    output logic [5:0] cnt,
    output logic [1:0] done,
    output logic [1:0] err,
    output logic       busy
);
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_gnt, w_gnt_nxt;
    logic [5:0] r_cnt, w_cnt_nxt;
    logic [1:0] r_done, w_done_nxt;
    logic [1:0] r_err, w_err_nxt;
    logic       r_ptr, w_ptr_nxt;
    logic [5:0] r_len, w_len_nxt;
    logic       r_owner, w_owner_nxt;

    logic [NUM_REQ-1:0]      w_req;
    logic [NUM_REQ-1:0][5:0] w_len;
    logic [NUM_REQ-1:0]      w_legal;
    logic                    w_win_vld;
    logic                    w_win;

    assign w_req = {req1, req0};
    assign w_len = {len1, len0};

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_chk
        timer_share_lenchk u_chk (
            .i_len   (w_len[g]),
            .o_legal (w_legal[g])
        );
    end

    // Pointer only matters under contention; a lone request always wins.
    assign w_win_vld = |w_req;
    assign w_win     = (&w_req) ? r_ptr : w_req[1];

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 2'b00;
        w_err_nxt   = 2'b00;
        w_ptr_nxt   = r_ptr;
        w_len_nxt   = r_len;
        w_owner_nxt = r_owner;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = 2'b00;
                w_cnt_nxt = 6'd0;
                if (w_win_vld) begin
                    if (w_legal[w_win]) begin
                        w_state_nxt = S_RUN;
                        w_gnt_nxt   = {w_win, ~w_win};
                        w_len_nxt   = w_len[w_win];
                        w_owner_nxt = w_win;
                    end else begin
                        w_err_nxt = {w_win, ~w_win};
                        w_ptr_nxt = ~w_win;
                    end
                end
            end
            S_RUN: begin
                // Owner dropping its request wins over a same-cycle completion.
                if (!w_req[r_owner]) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = 2'b00;
                    w_cnt_nxt   = 6'd0;
                    w_ptr_nxt   = ~r_owner;
                end else if (r_cnt == r_len - 6'd1) begin
                    w_state_nxt = S_DONE;
                    w_gnt_nxt   = 2'b00;
                    w_cnt_nxt   = 6'd0;
                    w_done_nxt  = {r_owner, ~r_owner};
                end else begin
                    w_cnt_nxt = r_cnt + 6'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_ptr_nxt   = ~r_owner;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_gnt_nxt   = 2'b00;
                w_cnt_nxt   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'b00;
            r_cnt   <= 6'd0;
            r_done  <= 2'b00;
            r_err   <= 2'b00;
            r_ptr   <= 1'b0;
            r_len   <= 6'd0;
            r_owner <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_ptr   <= w_ptr_nxt;
            r_len   <= w_len_nxt;
            r_owner <= w_owner_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign cnt  = r_cnt;
    assign done = r_done;
    assign err  = r_err;
    assign busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_timer_share_ctrl.sv
// Directed scoreboard bench for timer_share_ctrl: stimulus queues the expected
// outputs for each edge, a negedge monitor pops and compares them.

module tb_timer_share_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [5:0] len0 = 6'd0, len1 = 6'd0;
    logic [1:0] gnt, done, err;
    logic [5:0] cnt;
    logic       busy;

    typedef struct {
        string      name;
        logic [1:0] gnt;
        logic [5:0] cnt;
        logic [1:0] done;
        logic [1:0] err;
        logic       busy;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    timer_share_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .req0 (req0),
        .req1 (req1),
        .len0 (len0),
        .len1 (len1),
        .gnt  (gnt),
        .cnt  (cnt),
        .done (done),
        .err  (err),
        .busy (busy)
    );

    always @(negedge clk) begin
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_run++;
            if ({gnt, cnt, done, err, busy} !== {m_e.gnt, m_e.cnt, m_e.done, m_e.err, m_e.busy}) begin
                n_fail++;
                $display("FAIL %s: got gnt=%b cnt=%0d done=%b err=%b busy=%b, want gnt=%b cnt=%0d done=%b err=%b busy=%b",
                         m_e.name, gnt, cnt, done, err, busy,
                         m_e.gnt, m_e.cnt, m_e.done, m_e.err, m_e.busy);
            end
        end
    end

    // Queue what the outputs must be after the next rising edge, then take that edge.
    task automatic cyc(input string nm, input logic [1:0] g, input int c,
                       input logic [1:0] d, input logic [1:0] e, input logic b);
        exp_t x;
        x.name = nm; x.gnt = g; x.cnt = 6'(c); x.done = d; x.err = e; x.busy = b;
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm);
        cyc(nm, 2'b00, 0, 2'b00, 2'b00, 1'b0);
    endtask

    initial begin
        // reset state
        idle("rst_a");
        idle("rst_b");
        rst = 1'b1;
        idle("idle_noreq");

        // single request, len change after latch ignored
        req0 = 1'b1; len0 = 6'd3;
        cyc("single_c0", 2'b01, 0, 2'b00, 2'b00, 1'b1);
        len0 = 6'd1;
        cyc("single_c1", 2'b01, 1, 2'b00, 2'b00, 1'b1);
        cyc("single_c2", 2'b01, 2, 2'b00, 2'b00, 1'b1);
        cyc("single_done", 2'b00, 0, 2'b01, 2'b00, 1'b1);
        req0 = 1'b0;
        idle("single_idle");

        // illegal lengths; the winner is requester 0 alone
        req0 = 1'b1; len0 = 6'd0;
        cyc("illegal_len0", 2'b00, 0, 2'b00, 2'b01, 1'b0);
        len0 = 6'd42;
        cyc("illegal_len42", 2'b00, 0, 2'b00, 2'b01, 1'b0);
        // pointer now 1: contention with an illegal len1 rejects requester 1
        req1 = 1'b1; len1 = 6'd0;
        cyc("ptr_after_err", 2'b00, 0, 2'b00, 2'b10, 1'b0);

        // contention, pointer back at 0
        len0 = 6'd2; len1 = 6'd4;
        cyc("cont_g0_c0", 2'b01, 0, 2'b00, 2'b00, 1'b1);
        len0 = 6'd5;
        cyc("cont_g0_c1", 2'b01, 1, 2'b00, 2'b00, 1'b1);
        cyc("cont_done0", 2'b00, 0, 2'b01, 2'b00, 1'b1);
        idle("cont_idle0");
        for (int i = 0; i < 4; i++) cyc($sformatf("cont_g1_c%0d", i), 2'b10, i, 2'b00, 2'b00, 1'b1);
        cyc("cont_done1", 2'b00, 0, 2'b10, 2'b00, 1'b1);
        idle("cont_idle1");

        // regrant to 0 (len 5) then abort at cnt=2
        cyc("regrant_c0", 2'b01, 0, 2'b00, 2'b00, 1'b1);
        cyc("regrant_c1", 2'b01, 1, 2'b00, 2'b00, 1'b1);
        cyc("regrant_c2", 2'b01, 2, 2'b00, 2'b00, 1'b1);
        req0 = 1'b0; len1 = 6'd41;
        idle("abort");

        // pending requester 1 granted with the maximum length
        for (int i = 0; i <= 40; i++) cyc($sformatf("max_c%0d", i), 2'b10, i, 2'b00, 2'b00, 1'b1);
        cyc("max_done", 2'b00, 0, 2'b10, 2'b00, 1'b1);
        idle("max_idle");

        // reset in the middle of a run at cnt=17
        for (int i = 0; i <= 17; i++) cyc($sformatf("mid_c%0d", i), 2'b10, i, 2'b00, 2'b00, 1'b1);
        rst = 1'b0; req0 = 1'b1;
        idle("rst_mid");
        idle("rst_hold");
        rst = 1'b1;
        cyc("post_rst_g0", 2'b01, 0, 2'b00, 2'b00, 1'b1);

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/timer_share_ctrl.md
TIMER_SHARE_CTRL -- requirements
Module: timer_share_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit, the clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst, input, 1 bit, the reset; synchronous and active-low.
REQ-003 The block SHALL have the ports req0 and req1, input, 1 bit each, level-sensitive interval requests from requesters 0 and 1.
REQ-004 The block SHALL have the ports len0 and len1, input, 6 bits each, the requested interval length in clk cycles; legal range 1..41.
REQ-005 The block SHALL have the port gnt, output, 2 bits, a one-hot grant; bit i means requester i owns the shared counter.
REQ-006 The block SHALL have the port cnt, output, 6 bits, the value of the shared mod-41 counter.
REQ-007 The block SHALL have the port done, output, 2 bits, a one-cycle pulse on bit i when requester i's interval completes.
REQ-008 The block SHALL have the port err, output, 2 bits, a one-cycle pulse on bit i when requester i's request is rejected.
REQ-009 The block SHALL have the port busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-010 The block SHALL implement a registered FSM with the states IDLE, RUN and DONE.
REQ-011 In IDLE with no request pending, the block SHALL hold gnt=00 and cnt=0.
REQ-012 Arbitration SHALL be round-robin using a 1-bit pointer: with both requests high, the requester named by the pointer wins; with one request high, that requester wins.
REQ-013 In IDLE, a winner with a legal length SHALL cause, at the next edge: gnt=one-hot(winner), cnt=0, the length latched internally, and state=RUN.
REQ-014 In IDLE, a winner with an illegal length (0 or greater than 41) SHALL cause, at the next edge: a one-cycle err pulse on the winner's bit, no grant, the pointer set to the other requester, and state remaining IDLE.
REQ-015 In RUN, cnt SHALL increment by 1 per cycle; len changes after latching SHALL be ignored.
REQ-016 In RUN, when cnt equals the latched length minus 1, the next edge SHALL move to DONE with gnt=00, done=one-hot(owner), and cnt=0, so gnt is high for exactly len cycles.
REQ-017 cnt SHALL never exceed 40; the wrap from 40 to 0 SHALL coincide only with the completion of a len=41 interval.
REQ-018 DONE SHALL last one cycle, set the pointer to the non-owner, and return to IDLE.
REQ-019 If the owner drops its req during RUN, the next edge SHALL abort: gnt=00, cnt=0, no done pulse, pointer set to the other requester, state=IDLE.
REQ-020 A request held high through DONE SHALL be treated as a new request and SHALL be arbitrated in the following IDLE cycle.
REQ-021 The non-owner's req SHALL be ignored during RUN and DONE, and SHALL be neither lost nor errored while it is held.
REQ-022 The minimum spacing between consecutive grants SHALL be one DONE cycle plus one IDLE cycle.

Reset
REQ-023 When rst is 0 at a rising edge, the block SHALL set state=IDLE, gnt=00, cnt=0, done=00, err=00, busy=0, pointer=0, and the latched length=0.
REQ-024 Reset SHALL take priority over every other event, including reset mid-RUN; no done or err pulse SHALL be produced on reset.
REQ-025 The block SHALL produce no grant while rst is held at 0.

Verification
REQ-026 Single request: req0=1, len0=3 sampled in IDLE at edge k -> gnt=01 after edges k, k+1, k+2 with cnt=0,1,2; done=01 after edge k+3; IDLE after edge k+4.
REQ-027 Contention: req0=req1=1 from reset with len0=2, len1=4 -> gnt=01 for 2 cycles, done=01, one IDLE cycle, then gnt=10 for 4 cycles, done=10, then gnt=01 again if req0 is still high.
REQ-028 Maximum length: len1=41 -> cnt runs 0..40, gnt=10 for 41 cycles, done=10 coincides with cnt=0, and cnt never reaches 41.
REQ-029 Illegal length: req0=1, len0=0, req1=0 -> err=01 for one cycle, gnt stays 00, pointer becomes 1; the same check with len0=42 gives the same response.
REQ-030 Abort: req0 drops after gnt=01 with cnt=2 -> at the next edge gnt=00 and cnt=0, done stays 00, and a pending req1 is granted one IDLE cycle later.
REQ-031 Reset mid-run: rst=0 while gnt=10 and cnt=17 -> after that edge all outputs are 0 and the pointer is 0; after release with both requests high, requester 0 is granted first.
